// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: a shift stage collects W qualified bits, and a
// holding register presents each completed word on a valid/ready output.
module sipo_rx #(
    parameter int unsigned W         = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin,
    input  logic                 sin_valid,
    input  logic                 clr,
    output logic [W-1:0]         dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 overrun,
    output logic [$clog2(W)-1:0] bit_cnt
);

    localparam int unsigned   CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [W-1:0]  dout_q, dout_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovr_q, ovr_d;
    logic          complete;

    // Shift stage; clr dominates sin_valid and drops any partial word.
    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        complete = 1'b0;
        if (clr) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (sin_valid) begin
            if (MSB_FIRST) begin
                shreg_d = {shreg_q[W-2:0], sin};
            end else begin
                shreg_d = {sin, shreg_q[W-1:1]};
            end
            if (cnt_q == LAST) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output holding register; the handshake proceeds regardless of clr.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        ovr_d   = clr ? 1'b0 : ovr_q;
        unique case (state_q)
            StEmpty: begin
                if (complete) begin
                    dout_d  = shreg_d;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (complete) begin
                    if (dout_ready) begin
                        dout_d = shreg_d;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (dout_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            shreg_q <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == StFull);
    assign overrun    = ovr_q;
    assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: LSB-first and MSB-first instances share stimulus and are checked
// every cycle against a positional word-assembly model, plus directed literal checks.
module tb_sipo_rx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         clr = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] d0, d1;
    logic         dv0, dv1, ov0, ov1;
    logic [1:0]   bc0, bc1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sipo_rx #(.W(W), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .dout(d0), .dout_valid(dv0), .dout_ready(dout_ready), .overrun(ov0), .bit_cnt(bc0)
    );

    sipo_rx #(.W(W), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .clr(clr),
        .dout(d1), .dout_valid(dv1), .dout_ready(dout_ready), .overrun(ov1), .bit_cnt(bc1)
    );

    // Model: the k-th bit of a word lands at index k (LSB-first) or W-1-k (MSB-first).
    int           m_cnt = 0;
    logic [W-1:0] m_w0 = '0, m_w1 = '0;
    logic [W-1:0] m_dout0 = '0, m_dout1 = '0;
    logic         m_valid = 1'b0, m_ovr = 1'b0;
    logic         done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_w0 = '0; m_w1 = '0;
            m_dout0 = '0; m_dout1 = '0; m_valid = 1'b0; m_ovr = 1'b0;
        end else begin
            done = 1'b0;
            if (clr) begin
                m_cnt = 0; m_w0 = '0; m_w1 = '0; m_ovr = 1'b0;
            end else if (sin_valid) begin
                m_w0[m_cnt]         = sin;
                m_w1[W - 1 - m_cnt] = sin;
                m_cnt++;
                if (m_cnt == W) done = 1'b1;
            end
            if (done) begin
                if (!m_valid || dout_ready) begin
                    m_dout0 = m_w0; m_dout1 = m_w1; m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                m_cnt = 0; m_w0 = '0; m_w1 = '0;
            end else if (m_valid && dout_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_dout0", 32'(d0), 32'(m_dout0));
            chk("cmp_dout1", 32'(d1), 32'(m_dout1));
            chk("cmp_valid", {30'b0, dv1, dv0}, {30'b0, m_valid, m_valid});
            chk("cmp_ovr", {30'b0, ov1, ov0}, {30'b0, m_ovr, m_ovr});
            chk("cmp_cnt0", 32'(bc0), 32'(m_cnt));
            chk("cmp_cnt1", 32'(bc1), 32'(m_cnt));
        end
    end

    task automatic step(input logic b, input logic v, input logic r, input logic c);
        @(negedge clk);
        sin = b; sin_valid = v; dout_ready = r; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [3:0] bits, input logic r);
        for (int i = 0; i < 4; i++) step(bits[i], 1'b1, r, 1'b0);
    endtask

    logic [3:0] piso;

    initial begin
        #12;
        chk("rst_valid", {31'b0, dv0}, 32'd0);
        chk("rst_dout", 32'(d0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1,0,1,1 LSB-first -> D, MSB-first -> B
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("b3_valid", {31'b0, dv0}, 32'd0);
        chk("b3_cnt", 32'(bc0), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("lsb_D", 32'(d0), 32'hD);
        chk("msb_B", 32'(d1), 32'hB);
        chk("b4_valid", {31'b0, dv0}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_valid", {31'b0, dv0}, 32'd0);

        // Backpressure: D then 3 with no sink
        send4(4'hD, 1'b0);
        send4(4'h3, 1'b0);
        chk("bp_dout", 32'(d0), 32'hD);
        chk("bp_ovr", {31'b0, ov0}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_drain", {31'b0, dv0}, 32'd0);
        chk("bp_ovr_sticky", {31'b0, ov0}, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ovr", {31'b0, ov0}, 32'd0);

        // Simultaneous accept and completion
        send4(4'hA, 1'b0);
        chk("sim_A", 32'(d0), 32'hA);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("sim_5", 32'(d0), 32'h5);
        chk("sim_valid", {31'b0, dv0}, 32'd1);
        chk("sim_ovr", {31'b0, ov0}, 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Gaps then clr
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("gap_cnt", 32'(bc0), 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("gap_cnt3", 32'(bc0), 32'd3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_cnt", 32'(bc0), 32'd0);
        chk("clr_noword", {31'b0, dv0}, 32'd0);
        send4(4'h6, 1'b0);
        chk("gap_6", 32'(d0), 32'h6);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Loopback from an LSB-first 4-bit serializer loaded with 9
        piso = 4'h9;
        for (int i = 0; i < 4; i++) begin
            step(piso[0], 1'b1, 1'b0, 1'b0);
            piso = piso >> 1;
        end
        chk("loop_9", 32'(d0), 32'h9);

        // Async reset while FULL and mid-word
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_cnt", 32'(bc0), 32'd2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, dv0}, 32'd0);
        chk("arst_ovr", {31'b0, ov0}, 32'd0);
        chk("arst_cnt", 32'(bc0), 32'd0);
        chk("arst_dout", 32'(d0), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized phase checked by the per-cycle compare process
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) rst = 1'b1;
            sin        = 1'($urandom_range(0, 1));
            sin_valid  = ($urandom_range(0, 9) < 7);
            dout_ready = ($urandom_range(0, 9) < 4);
            clr        = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
